// File: rtl/aes_ctrl_pkg.sv
// Shared constants and state encoding for the AES-CTR engine control path.
package aes_ctrl_pkg;

   localparam int unsigned AES_BLOCK_W     = 128;
   localparam int unsigned DEFAULT_TIMEOUT = 4096;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } aes_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = IDX_W'((32'(ptr) + i) % N_REQ);
         if (!any && req[cand]) begin
            gnt[cand] = 1'b1;
            idx       = cand;
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/aes_ctr_arbiter.sv
// Shares one start/done AES-CTR engine between N_REQ requesters, round-robin,
// with a watchdog that converts a missing done into an error response.
module aes_ctr_arbiter
   import aes_ctrl_pkg::*;
#(
   parameter int unsigned N_REQ          = 2,
   parameter int unsigned DATA_W         = AES_BLOCK_W,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        rsp_valid,
   input  logic [N_REQ-1:0]        rsp_ready,
   output logic [DATA_W-1:0]       rsp_data,
   output logic                    rsp_err,
   output logic                    eng_start,
   output logic [DATA_W-1:0]       eng_data_in,
   input  logic [DATA_W-1:0]       eng_data_out,
   input  logic                    eng_done,
   output logic                    busy,
   output logic                    timeout_err,
   output logic [31:0]             blocks_done
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   aes_state_e        state_q, state_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic              eng_start_q, eng_start_d;
   logic [DATA_W-1:0] eng_data_in_q, eng_data_in_d;
   logic              busy_q, busy_d;
   logic              timeout_err_q, timeout_err_d;
   logic [31:0]       blocks_done_q, blocks_done_d;
   logic [WD_W-1:0]   wd_q, wd_d;

   logic [N_REQ-1:0]  arb_gnt;
   logic [IDX_W-1:0]  arb_idx;
   logic              arb_any;
   logic [DATA_W-1:0] req_blk [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign req_blk[i] = req_data[i*DATA_W +: DATA_W];
   end

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   // Accept is a same-cycle pulse; masked while reset is applied so no block is taken.
   assign req_ready   = (state_q == IDLE && !reset) ? arb_gnt : '0;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_err     = rsp_err_q;
   assign eng_start   = eng_start_q;
   assign eng_data_in = eng_data_in_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;
   assign blocks_done = blocks_done_q;

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      grant_d       = grant_q;
      rsp_data_d    = rsp_data_q;
      rsp_err_d     = rsp_err_q;
      eng_data_in_d = eng_data_in_q;
      timeout_err_d = timeout_err_q;
      blocks_done_d = blocks_done_q;
      wd_d          = wd_q;
      unique case (state_q)
         IDLE: begin
            if (arb_any) begin
               grant_d       = arb_idx;
               eng_data_in_d = req_blk[arb_idx];
               state_d       = ISSUE;
            end
         end
         ISSUE: begin
            wd_d    = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // done takes priority over a watchdog expiry in the same cycle
            if (eng_done) begin
               rsp_data_d = eng_data_out;
               rsp_err_d  = 1'b0;
               state_d    = RESP;
            end else if (wd_q == WD_LAST) begin
               rsp_data_d    = '0;
               rsp_err_d     = 1'b1;
               timeout_err_d = 1'b1;
               state_d       = RESP;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready[grant_q]) begin
               rr_ptr_d      = IDX_W'((32'(grant_q) + 32'd1) % N_REQ);
               blocks_done_d = blocks_done_q + 32'd1;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      rsp_valid_d = (state_d == RESP) ? (N_REQ'(1) << grant_d) : '0;
      eng_start_d = (state_d == ISSUE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         grant_q       <= '0;
         rsp_valid_q   <= '0;
         rsp_data_q    <= '0;
         rsp_err_q     <= 1'b0;
         eng_start_q   <= 1'b0;
         eng_data_in_q <= '0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         blocks_done_q <= '0;
         wd_q          <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_q       <= grant_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_err_q     <= rsp_err_d;
         eng_start_q   <= eng_start_d;
         eng_data_in_q <= eng_data_in_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
         blocks_done_q <= blocks_done_d;
         wd_q          <= wd_d;
      end
   end

endmodule

// File: tb/tb_aes_ctr_arbiter.sv
// Bench for aes_ctr_arbiter: vector table of transactions against an engine
// model, with a response scoreboard and hand-written reset/stray-done sequences.
module tb_aes_ctr_arbiter;

   localparam int N   = 2;
   localparam int W   = 128;
   localparam int TMO = 16;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0]   rsp_valid;
   logic [N-1:0]   rsp_ready = '0;
   logic [W-1:0]   rsp_data;
   logic           rsp_err;
   logic           eng_start;
   logic [W-1:0]   eng_data_in;
   logic [W-1:0]   eng_data_out;
   logic           eng_done;
   logic           busy;
   logic           timeout_err;
   logic [31:0]    blocks_done;

   always #5 clk = ~clk;

   aes_ctr_arbiter #(
      .N_REQ          (N),
      .DATA_W         (W),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_data     (req_data),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_err      (rsp_err),
      .eng_start    (eng_start),
      .eng_data_in  (eng_data_in),
      .eng_data_out (eng_data_out),
      .eng_done     (eng_done),
      .busy         (busy),
      .timeout_err  (timeout_err),
      .blocks_done  (blocks_done)
   );

   function automatic logic [W-1:0] eng_fn(input logic [W-1:0] d);
      return {d[63:0], d[127:64]} ^ 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
   endfunction

   // Engine model: done pulse eng_lat cycles after the start cycle
   int           eng_lat = 12;
   bit           eng_hang = 1'b0;
   logic         stray_done = 1'b0;
   logic         mdl_done = 1'b0;
   logic         mdl_busy = 1'b0;
   int           mdl_cnt = 0;
   logic [W-1:0] mdl_buf = '0;
   logic [W-1:0] mdl_out = '0;

   always @(posedge clk) begin
      mdl_done <= 1'b0;
      if (reset) begin
         mdl_busy <= 1'b0;
      end else if (eng_start && !eng_hang) begin
         mdl_busy <= 1'b1;
         mdl_cnt  <= eng_lat - 1;
         mdl_buf  <= eng_data_in;
      end else if (mdl_busy) begin
         if (mdl_cnt == 1) begin
            mdl_done <= 1'b1;
            mdl_out  <= eng_fn(mdl_buf);
            mdl_busy <= 1'b0;
         end else begin
            mdl_cnt <= mdl_cnt - 1;
         end
      end
   end

   assign eng_done     = mdl_done | stray_done;
   assign eng_data_out = stray_done ? 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF : mdl_out;

   typedef struct {
      logic [1:0] valid;
      logic [W-1:0] d0;
      logic [W-1:0] d1;
      int lat;
      int bp;
      int exp_g;
      bit hang;
      bit hold;
      bit stray;
   } vec_t;

   typedef struct {
      int g;
      logic [W-1:0] d;
      bit err;
   } exp_t;

   vec_t vecs [13];
   exp_t sb [$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   exp_blocks = 0;
   bit   exp_sticky = 1'b0;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic vec_t mk(input logic [1:0] va, input logic [W-1:0] a, input logic [W-1:0] b,
                               input int lat, input int bp, input int g,
                               input bit hang, input bit hold, input bit stray);
      vec_t v;
      v.valid = va; v.d0 = a; v.d1 = b; v.lat = lat; v.bp = bp; v.exp_g = g;
      v.hang = hang; v.hold = hold; v.stray = stray;
      return v;
   endfunction

   function automatic logic [W-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Caller is positioned just after a negedge in a cycle where the DUT is idle.
   task automatic run_txn(input vec_t v, input int id);
      int           n;
      int           c;
      int           g;
      bit           ok;
      exp_t         e;
      logic [W-1:0] blk;
      logic [W-1:0] first_d;
      eng_lat    = v.lat;
      eng_hang   = v.hang;
      req_valid  = v.valid;
      req_data   = {v.d1, v.d0};
      rsp_ready  = '0;
      stray_done = v.stray;
      #1;
      n = 0;
      while (req_ready == '0 && n < 8) begin
         @(negedge clk); #1;
         n++;
      end
      chk($sformatf("v%0d accept_wait", id), W'(n), W'(0));
      if (req_ready == '0) return;
      g = v.exp_g;
      chk($sformatf("v%0d grant", id), W'(req_ready), W'(1) << g);
      chk($sformatf("v%0d idle_busy", id), W'(busy), W'(0));
      chk($sformatf("v%0d blocks_before", id), W'(blocks_done), W'(exp_blocks));
      blk   = (g == 1) ? v.d1 : v.d0;
      e.g   = g;
      e.d   = v.hang ? '0 : eng_fn(blk);
      e.err = v.hang;
      sb.push_back(e);
      // cycle 1: start pulse with the latched block
      @(negedge clk);
      if (!v.hold) req_valid = '0;
      #1;
      chk($sformatf("v%0d eng_start", id), W'(eng_start), W'(1));
      chk($sformatf("v%0d eng_data_in", id), eng_data_in, blk);
      // cycle 2: start must already be gone
      @(negedge clk);
      stray_done = 1'b0;
      #1;
      chk($sformatf("v%0d start_once", id), W'(eng_start), W'(0));
      c  = 2;
      ok = 1'b1;
      while (rsp_valid == '0 && c < 60) begin
         if (eng_data_in !== blk || req_ready != '0 || busy !== 1'b1) ok = 1'b0;
         @(negedge clk); #1;
         c++;
      end
      chk($sformatf("v%0d wait_stable", id), W'(ok), W'(1));
      chk($sformatf("v%0d rsp_cycle", id), W'(c), v.hang ? W'(TMO + 2) : W'(v.lat + 2));
      first_d = rsp_data;
      ok = 1'b1;
      for (int b = 0; b < v.bp; b++) begin
         rsp_ready = ~(2'b01 << g);
         @(negedge clk); #1;
         if (rsp_valid !== (2'b01 << g) || rsp_data !== first_d || req_ready != '0) ok = 1'b0;
      end
      if (v.bp > 0) chk($sformatf("v%0d backpressure", id), W'(ok), W'(1));
      if (sb.size() == 0) begin
         chk($sformatf("v%0d sb_nonempty", id), W'(0), W'(1));
         return;
      end
      e = sb.pop_front();
      chk($sformatf("v%0d rsp_valid", id), W'(rsp_valid), W'(1) << e.g);
      chk($sformatf("v%0d rsp_data", id), rsp_data, e.d);
      chk($sformatf("v%0d rsp_err", id), W'(rsp_err), W'(e.err));
      rsp_ready = 2'b01 << g;
      exp_blocks++;
      if (v.hang) exp_sticky = 1'b1;
      @(negedge clk);
      rsp_ready = '0;
      #1;
      chk($sformatf("v%0d rsp_drop", id), W'(rsp_valid), W'(0));
      chk($sformatf("v%0d blocks_after", id), W'(blocks_done), W'(exp_blocks));
      chk($sformatf("v%0d timeout_err", id), W'(timeout_err), W'(exp_sticky));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench stalled");
   end

   initial begin
      bit ok;
      vecs[0]  = mk(2'b01, 128'h00112233_44556677_8899AABB_CCDDEEFF, '0, 12, 0, 0, 0, 0, 0);
      vecs[1]  = mk(2'b11, rnd128(), rnd128(), 5, 20, 1, 0, 1, 0);
      for (int i = 0; i < 6; i++)
         vecs[2+i] = mk(2'b11, rnd128(), rnd128(), 3 + i, i % 3, i % 2, 0, 1, 0);
      vecs[8]  = mk(2'b01, rnd128(), rnd128(), 4, 0, 0, 1, 0, 0);
      vecs[9]  = mk(2'b11, rnd128(), rnd128(), 6, 0, 1, 0, 0, 0);
      vecs[10] = mk(2'b01, rnd128(), rnd128(), 4, 0, 0, 0, 0, 1);
      vecs[11] = mk(2'b01, rnd128(), rnd128(), 16, 0, 0, 0, 0, 0);
      vecs[12] = mk(2'b10, rnd128(), rnd128(), 2, 3, 1, 0, 0, 0);

      // reset values, with requests pending during reset
      req_valid = 2'b11;
      repeat (3) @(negedge clk);
      #1;
      chk("rst req_ready", W'(req_ready), W'(0));
      chk("rst rsp_valid", W'(rsp_valid), W'(0));
      chk("rst rsp_data", rsp_data, W'(0));
      chk("rst rsp_err", W'(rsp_err), W'(0));
      chk("rst eng_start", W'(eng_start), W'(0));
      chk("rst eng_data_in", eng_data_in, W'(0));
      chk("rst busy", W'(busy), W'(0));
      chk("rst timeout_err", W'(timeout_err), W'(0));
      chk("rst blocks_done", W'(blocks_done), W'(0));

      // reset mid-WAIT, then a late done one cycle later
      reset     = 1'b0;
      req_valid = 2'b01;
      req_data  = {128'h0, 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555};
      #1;
      chk("midwait accept", W'(req_ready), W'(1));
      @(negedge clk);
      req_valid = '0;
      repeat (4) @(negedge clk);
      #1;
      chk("midwait busy", W'(busy), W'(1));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midwait busy_clr", W'(busy), W'(0));
      chk("midwait eng_data_in_clr", eng_data_in, W'(0));
      chk("midwait rsp_valid_clr", W'(rsp_valid), W'(0));
      @(negedge clk);
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (rsp_valid != '0 || busy !== 1'b0 || rsp_data != '0) ok = 1'b0;
      end
      chk("midwait late_done_ignored", W'(ok), W'(1));
      chk("midwait blocks_done", W'(blocks_done), W'(0));

      for (int i = 0; i < 13; i++) run_txn(vecs[i], i);

      chk("sb drained", W'(sb.size()), W'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
